xadc_drp_reader: RTL
====================

# xadc_drp_reader

Upstream acquisition stage for the temperature-conversion block. It periodically issues a DRP read to the XADC hard macro, waits for `drdy`, and extracts the 12-bit conversion result from `do[15:4]`. It box-car averages 2^AVG_LOG2 samples and presents a registered raw sample and an averaged sample with a one-cycle valid strobe. The conversion logic downstream consumes `avg_sample`/`avg_valid` in place of sampling `do_out` directly.

## Interface
- `DADDR`, 7'h00: DRP address read each period (7'h00 = on-chip temperature).
- `CLK_DIV`, 100000: clock cycles per read request (1 kHz at 100 MHz). Must satisfy CLK_DIV ≥ TIMEOUT + 4.
- `AVG_LOG2`, 2: log2 of samples per average (0..4).
- `TIMEOUT`, 64: maximum number of cycles spent waiting for `drdy_in`.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `daddr_out` out 7: DRP address. Constant DADDR.
- `den_out` out 1: DRP enable. One-cycle pulse per read.
- `dwe_out` out 1: DRP write enable. Tied 0.
- `di_out` out 16: DRP write data. Tied 0.
- `do_in` in 16: DRP read data. Only bits [15:4] are used.
- `drdy_in` in 1: DRP data-ready strobe.
- `raw_sample` out 12: last accepted `do_in[15:4]`.
- `avg_sample` out 12: last completed average.
- `avg_valid` out 1: one-cycle strobe when `avg_sample` updates.
- `timeout_err` out 1: sticky flag. Set on a DRP timeout; cleared only by reset.

## Operation
- Period counter `pcnt` counts 0..CLK_DIV-1 and wraps. It runs free, independent of the FSM. A tick occurs when `pcnt == CLK_DIV-1`.
- FSM states and transitions:
  - WAIT: on tick, go to REQ. `drdy_in` is ignored in this state.
  - REQ: `den_out`=1 for exactly this cycle. Unconditionally go to BUSY. `drdy_in` is ignored in REQ.
  - BUSY: the wait counter `wcnt` increments each cycle.
    - On `drdy_in`=1: capture the sample (see below), clear `wcnt`, go to WAIT.
    - Else, if `wcnt == TIMEOUT-1`: set `timeout_err`, clear `wcnt`, go to WAIT. The sample is discarded and the accumulator is unchanged.
- Sample capture:
  - `raw_sample` ← `do_in[15:4]`.
  - `acc` (12+AVG_LOG2 bits, no overflow possible) ← `acc + do_in[15:4]`.
  - `n` ← `n+1`.
- Window completion: when the captured sample is number 2^AVG_LOG2 (n == 2^AVG_LOG2-1 before the increment):
  - `avg_sample` ← `(acc + do_in[15:4]) >> AVG_LOG2`. This is a truncating shift.
  - `acc` ← 0, `n` ← 0.
  - `avg_valid` ← 1 for one cycle.
- AVG_LOG2=0: every accepted sample produces `avg_valid`, with `avg_sample` equal to the raw value.
- A tick arriving while in REQ or BUSY is dropped and not queued. The parameter constraint makes this unreachable in normal operation.
- Reset mid-read: the FSM returns to WAIT and `pcnt`, `wcnt`, `acc`, and `n` clear. A `drdy_in` that arrives after reset is ignored because the FSM is in WAIT.

## Timing
- Reset values: `den_out`=0, `raw_sample`=0, `avg_sample`=0, `avg_valid`=0, `timeout_err`=0, state=WAIT, all counters 0. `daddr_out`=DADDR, `dwe_out`=0, `di_out`=0 at all times.
- All outputs are registered or decoded directly from the state register. There is no combinational path from `do_in`/`drdy_in` to any output.
- First read after reset release: `den_out` is high during cycle CLK_DIV. Cycle 0 is the first cycle with `reset`=0.
- REQ→BUSY takes 1 cycle.
- Latency from `drdy_in` (cycle t):
  - `raw_sample` is valid at t+1.
  - `avg_valid`/`avg_sample` are valid at t+1 on the window's last sample.
- Timeout: `timeout_err` rises TIMEOUT cycles after entering BUSY, provided `drdy_in` never arrives.
- Read period is exactly CLK_DIV cycles, den to den, regardless of `drdy_in` latency or timeout.

## Test plan
Bench parameters: CLK_DIV=16, TIMEOUT=8, AVG_LOG2=2, DADDR=7'h00.
1. **First read after reset.** Release reset and respond to nothing. Required:
   - `den_out` is high only in cycle 16, with `daddr_out`=0x00 and `dwe_out`=0.
   - The next `den_out` is in cycle 32.
   - All outputs stay 0 except `timeout_err`, which rises at cycle 25.
2. **Average of four samples.** Respond 2 cycles after each den with `do_in` = 0x1230, 0x1240, 0x1250, 0x1260. Required:
   - `raw_sample` steps through 0x123, 0x124, 0x125, 0x126.
   - After the 4th `drdy_in`: `avg_sample`=0x124 and `avg_valid` is high for exactly 1 cycle.
   - `timeout_err`=0.
3. **Full scale.** Four responses of `do_in`=0xFFFF. Required: `avg_sample`=0xFFF, with no wrap. The low nibble is ignored.
4. **Timeout then late `drdy_in`.** Withhold `drdy_in` for one read, then pulse it 10 cycles after that den. Required:
   - `timeout_err`=1, sticky.
   - `raw_sample` is unchanged and no sample is counted.
   - The next four good responses (0x0100 each) give `avg_sample`=0x010.
5. **Reset mid-window.**
   - Stimulus: accept two samples of 0xFFF0, then assert `reset` for 1 cycle while in BUSY, then supply four samples of 0x0040.
   - Required: all outputs return to 0 and the next `avg_sample`=0x004, proving `acc` and `n` were cleared.
6. **Early `drdy_in` ignored.** Assert `drdy_in` during REQ and during WAIT. Required: no capture; capture happens only on `drdy_in` in BUSY.

Source files
------------

// File: rtl/xadc_drp_reader.sv
// xadc_drp_reader: periodic XADC DRP read, 12-bit result extraction and box-car averaging
module xadc_drp_reader #(
  parameter logic [6:0] DADDR    = 7'h00,
  parameter int         CLK_DIV  = 100000,
  parameter int         AVG_LOG2 = 2,
  parameter int         TIMEOUT  = 64
) (
  input  logic        clk,
  input  logic        reset,
  output logic [6:0]  daddr_out,
  output logic        den_out,
  output logic        dwe_out,
  output logic [15:0] di_out,
  input  logic [15:0] do_in,
  input  logic        drdy_in,
  output logic [11:0] raw_sample,
  output logic [11:0] avg_sample,
  output logic        avg_valid,
  output logic        timeout_err
);
  localparam int PW = $clog2(CLK_DIV + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int AW = 12 + AVG_LOG2;
  localparam int NW = AVG_LOG2 + 1;
  typedef enum logic [1:0] {WAIT, REQ, BUSY} state_t;
  state_t state, state_nx;
  logic [PW-1:0] pcnt;
  logic [WW-1:0] wcnt;
  logic [AW-1:0] acc, sum;
  logic [NW-1:0] n;
  logic tick, take, expire, last, unused;
  assign tick = pcnt == PW'(CLK_DIV - 1);
  assign take = state == BUSY && drdy_in;
  assign expire = state == BUSY && !drdy_in && wcnt == WW'(TIMEOUT - 1);
  assign last = n == NW'((1 << AVG_LOG2) - 1);
  assign sum = acc + AW'(do_in[15:4]);
  assign daddr_out = DADDR;
  assign dwe_out = 1'b0;
  assign di_out = '0;
  assign unused = ^do_in[3:0];
  always_comb begin
    state_nx = (state == WAIT && tick) ? REQ :
               state == REQ ? BUSY :
               (state == BUSY && !take && !expire) ? BUSY : WAIT;
    den_out = state == REQ;
  end
  always_ff @(posedge clk)
    state <= reset ? WAIT : state_nx;
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt <= '0;
      wcnt <= '0;
      acc <= '0;
      n <= '0;
      raw_sample <= '0;
      avg_sample <= '0;
      avg_valid <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
      wcnt <= (state != BUSY || take || expire) ? '0 : wcnt + 1'b1;
      avg_valid <= take && last;
      timeout_err <= timeout_err | expire;
      if (take) begin
        raw_sample <= do_in[15:4];
        acc <= last ? '0 : sum;
        n <= last ? '0 : n + 1'b1;
        if (last) avg_sample <= 12'(sum >> AVG_LOG2);
      end
    end
  end
endmodule
